csa_add_arbiter: RTL and testbench
==================================

# csa_add_arbiter

Shares one 8-bit carry-skip adder between two requesters, each issuing multi-byte add bursts over a valid/ready interface. The block arbitrates round-robin at burst boundaries, locks the grant for the length of a burst, and chains the carry between beats so a burst of N beats computes an N-byte sum least-significant byte first. It sits between the request sources and a downstream consumer, with one registered response slot.

## Interface
- `W`, 8, operand and sum width; only 8 is supported.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  2  per-requester beat valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester beat accept; at most one bit high in any cycle.
- `req_a0`, `req_b0`  in  W  requester 0 operands.
- `req_a1`, `req_b1`  in  W  requester 1 operands.
- `req_last`  in  2  per-requester flag marking the final beat of a burst.
- `rsp_valid`  out  1  response slot holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_sum`  out  W  byte sum, computed as a + b + chained carry.
- `rsp_cout`  out  1  carry-out of this beat; on the last beat it is the burst's final carry.
- `rsp_id`  out  1  requester that issued the beat.
- `rsp_last`  out  1  copy of `req_last` for the beat.

## Operation
- State machine states:
  - IDLE: no burst in progress.
  - BURST: grant is locked to requester `gnt`.
- Round-robin pointer `rr`:
  - Reset value is 0.
  - In IDLE, the winner is `rr` if `req_valid[rr]` is high, else the other requester if its valid is high.
  - The winner is selected combinationally and can be accepted in the same cycle.
- Response slot free: `slot_free = !rsp_valid || rsp_ready`.
- Ready rule: `req_ready[i] = slot_free && (IDLE ? winner==i : gnt==i)`.
- Beat accepted when `req_valid[i] && req_ready[i]`:
  - The adder computes a_i + b_i + `carry`. `carry` is forced to 0 on the first beat of a burst, i.e. when accepted in IDLE.
  - The response registers load sum, cout, id and last; `rsp_valid` is set to 1.
  - If last=0: `carry` <= cout; state becomes BURST with `gnt` = i (or stays BURST).
  - If last=1: `carry` <= 0; state becomes IDLE; `rr` <= ~i.
  - A single-beat burst (last=1 accepted in IDLE) never enters BURST.
- Accepted with no new beat and `rsp_ready` high: `rsp_valid` <= 0.
- Burst lock:
  - While in BURST, the other requester is never granted, even if the owner deasserts valid.
  - The lock is released only by the owner's last beat.
- Backpressure: when `rsp_valid && !rsp_ready`, all response outputs hold stable and both `req_ready` bits are 0.
- Arithmetic: 8-bit sum, no saturation; the carry is carried across beats only.
- Reset values: `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `rsp_last`=0, `req_ready`=0 during reset.
  - Internal reset values: `carry`=0, state=IDLE, `rr`=0, `gnt`=0.
  - Reset mid-burst abandons the burst. The next accepted beat starts a new burst with carry 0.

## Timing
- Beat accepted in cycle n gives `rsp_valid` and data valid in cycle n+1.
- Throughput is one beat per cycle while `rsp_ready` stays high.
- Arbitration adds zero cycles: a burst start is accepted in the same cycle it wins.
- Back-to-back bursts from different requesters need no idle cycle between them.
- The adder path is combinational from operand mux to response register: one cycle.

## Structure
- Package `csa_arb_pkg` holds:
  - the state enum {IDLE, BURST};
  - `NREQ`=2;
  - `ID_W`=1.
- Sub-module `csa8_core`: combinational 8-bit carry-skip adder with inputs a, b, cin and outputs sum, cout.
  - It is built as two 4-bit ripple blocks with a block-propagate skip mux.
  - It is instantiated once, fed by the granted-requester operand mux.

## Test plan
- Single beat: req0 sends a=0x0F, b=0x01, last=1 → next cycle rsp_sum=0x10, rsp_cout=0, rsp_id=0, rsp_last=1.
- Two-beat burst: req1 sends (0xFF, 0x01, last=0) then (0x00, 0x00, last=1) → rsp_sum=0x00 with cout=1, then rsp_sum=0x01 with cout=0; both have id=1.
- Contention from reset:
  - Stimulus: both requesters hold continuous single-beat requests.
  - Required: the rsp_id sequence is 0,1,0,1…; exactly one `req_ready` bit is high per cycle.
- Burst lock:
  - Stimulus: req0 sends a 3-beat burst with a 2-cycle valid gap after beat 1; req1 is valid throughout.
  - Required: no req1 beat is accepted until req0's last beat is accepted; req1 is accepted in the following cycle.
- Backpressure:
  - Stimulus: `rsp_ready` is held low for 3 cycles while a result is pending.
  - Required: `rsp_*` stays stable, `req_ready`=00, no beat is lost or duplicated after release.
- Reset mid-burst:
  - Stimulus: `rst_n` is pulled low after req0's beat (0xFF, 0x01, last=0).
  - Required: after reset, req0 sends (0x00, 0x00, last=1) → rsp_sum=0x00, showing carry 0.

Source files
------------

// File: rtl/csa_arb_pkg.sv
// Shared types and sizes for the two-requester carry-skip adder arbiter.
package csa_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam int NREQ = 2;
    localparam int ID_W = 1;

endpackage

// File: rtl/csa8_core.sv
// Combinational 8-bit carry-skip adder: two 4-bit ripple blocks, each
// bypassed by its block-propagate signal when every bit position propagates.
module csa8_core (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic blkPropLo;
    logic blkPropHi;
    logic carryMid;
    logic rc;

    assign blkPropLo = &(a[3:0] ^ b[3:0]);
    assign blkPropHi = &(a[7:4] ^ b[7:4]);

    // The skip mux selects the block carry-in whenever the whole block propagates.
    always_comb begin
        sum      = '0;
        rc       = cin;
        carryMid = 1'b0;
        cout     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ rc;
            rc     = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc);
        end
        carryMid = blkPropLo ? cin : rc;
        rc       = carryMid;
        for (int i = 4; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ rc;
            rc     = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc);
        end
        cout = blkPropHi ? carryMid : rc;
    end

endmodule

// File: rtl/csa_add_arbiter.sv
// Round-robin arbiter sharing one 8-bit carry-skip adder between two burst
// requesters; carry is chained across the beats of a locked burst.
module csa_add_arbiter
    import csa_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [W-1:0]    req_a0,
    input  logic [W-1:0]    req_b0,
    input  logic [W-1:0]    req_a1,
    input  logic [W-1:0]    req_b1,
    input  logic [NREQ-1:0] req_last,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_sum,
    output logic            rsp_cout,
    output logic [ID_W-1:0] rsp_id,
    output logic            rsp_last
);

    state_t          state_q;
    logic [ID_W-1:0] gnt_q;
    logic [ID_W-1:0] rr_q;
    logic            carry_q;
    logic            rsp_valid_q;
    logic [W-1:0]    rsp_sum_q;
    logic            rsp_cout_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            rsp_last_q;

    logic            slotFree;
    logic [ID_W-1:0] selId;
    logic            accept;
    logic            lastSel;
    logic            cin;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic [W-1:0]    sum_d;
    logic            cout_d;

    // In IDLE the winner is picked combinationally so a burst start is accepted
    // the same cycle it wins; in BURST the owner keeps the grant even if idle.
    always_comb begin
        slotFree = !rsp_valid_q || rsp_ready;
        if (state_q == BURST) begin
            selId = gnt_q;
        end else if (req_valid[rr_q]) begin
            selId = rr_q;
        end else begin
            selId = ~rr_q;
        end
        req_ready = '0;
        if (rst_n && slotFree && (state_q == BURST || (|req_valid))) begin
            req_ready[selId] = 1'b1;
        end
        accept  = |(req_valid & req_ready);
        opA     = selId ? req_a1 : req_a0;
        opB     = selId ? req_b1 : req_b0;
        lastSel = req_last[selId];
        cin     = (state_q == BURST) && carry_q;
    end

    csa8_core u_core (
        .a    (opA),
        .b    (opB),
        .cin  (cin),
        .sum  (sum_d),
        .cout (cout_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_q        <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_sum_q   <= sum_d;
            rsp_cout_q  <= cout_d;
            rsp_id_q    <= selId;
            rsp_last_q  <= lastSel;
            if (lastSel) begin
                carry_q <= 1'b0;
                state_q <= IDLE;
                rr_q    <= ~selId;
            end else begin
                carry_q <= cout_d;
                state_q <= BURST;
                gnt_q   <= selId;
            end
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_csa_add_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// burst-level model that predicts each response byte from the full multi-byte sum.
module tb_csa_add_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0] req_last;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_sum;
    logic       rsp_cout;
    logic [0:0] rsp_id;
    logic       rsp_last;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Model state: burst owner (-1 = none), round-robin pointer, operand prefixes.
    int              mOwner;
    int              mRr;
    int              beatIdx;
    longint unsigned accA, accB;
    logic            expValid;
    logic [7:0]      expSum;
    logic            expCout;
    logic            expId;
    logic            expLast;

    logic       pendValid [2];
    logic [7:0] pendA [2];
    logic [7:0] pendB [2];
    logic       pendLast [2];
    int         burstLen [2];

    csa_add_arbiter #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic driveInputs(input logic [1:0] valid, input logic [7:0] a0, input logic [7:0] b0,
                               input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] last,
                               input logic rdy);
        req_valid = valid;
        req_a0    = a0;
        req_b0    = b0;
        req_a1    = a1;
        req_b1    = b1;
        req_last  = last;
        rsp_ready = rdy;
    endtask

    // Checks one cycle at the falling edge, then advances the model by the rules.
    task automatic stepCycle(output logic [1:0] accMask);
        logic [1:0]      expReady;
        logic            slotFree;
        int              i;
        longint unsigned s;
        @(negedge clk);
        slotFree = !expValid || rsp_ready;
        expReady = 2'b00;
        if (slotFree) begin
            if (mOwner >= 0) expReady[mOwner] = 1'b1;
            else if (req_valid[mRr]) expReady[mRr] = 1'b1;
            else if (req_valid[1-mRr]) expReady[1-mRr] = 1'b1;
        end
        checkOutput("req_ready", {30'd0, req_ready}, {30'd0, expReady});
        checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, expValid});
        if (expValid) begin
            checkOutput("rsp_sum", {24'd0, rsp_sum}, {24'd0, expSum});
            checkOutput("rsp_cout", {31'd0, rsp_cout}, {31'd0, expCout});
            checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, expId});
            checkOutput("rsp_last", {31'd0, rsp_last}, {31'd0, expLast});
        end
        accMask = expReady & req_valid;
        if (accMask != 2'b00) begin
            i = accMask[1] ? 1 : 0;
            if (mOwner < 0) begin
                accA    = 0;
                accB    = 0;
                beatIdx = 0;
            end
            accA    = accA + (longint'(i == 1 ? req_a1 : req_a0) << (8 * beatIdx));
            accB    = accB + (longint'(i == 1 ? req_b1 : req_b0) << (8 * beatIdx));
            s       = accA + accB;
            expSum  = 8'((s >> (8 * beatIdx)) & 64'hFF);
            expCout = 1'((s >> (8 * beatIdx + 8)) & 64'h1);
            expId   = 1'(i);
            expLast = req_last[i];
            expValid = 1'b1;
            beatIdx++;
            if (req_last[i]) begin
                mOwner = -1;
                mRr    = 1 - i;
            end else begin
                mOwner = i;
            end
        end else if (rsp_ready) begin
            expValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] a0, input logic [7:0] b0,
                                 input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] last,
                                 input logic rdy);
        logic [1:0] acc;
        driveInputs(valid, a0, b0, a1, b1, last, rdy);
        stepCycle(acc);
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_ready2", {30'd0, req_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_sum", {24'd0, rsp_sum}, 32'd0);
        checkOutput("reset_rsp_cout", {31'd0, rsp_cout}, 32'd0);
        checkOutput("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        checkOutput("reset_rsp_last", {31'd0, rsp_last}, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 2'b00;
        mOwner    = -1;
        mRr       = 0;
        beatIdx   = 0;
        accA      = 0;
        accB      = 0;
        expValid  = 1'b0;
        expSum    = 8'h00;
        expCout   = 1'b0;
        expId     = 1'b0;
        expLast   = 1'b0;
    endtask

    initial begin
        logic [1:0] acc;
        logic [7:0] heldSum;
        logic       newLast;
        driveInputs(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
        resetDut();

        $display("[TB] single beat");
        applyStimulus(2'b01, 8'h0F, 8'h01, 8'h00, 8'h00, 2'b01, 1'b1);
        checkOutput("single_sum", {24'd0, rsp_sum}, 32'h10);
        checkOutput("single_last", {31'd0, rsp_last}, 32'd1);
        applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);

        $display("[TB] two-beat burst");
        applyStimulus(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 2'b00, 1'b1);
        checkOutput("burst_b0_sum", {24'd0, rsp_sum}, 32'h00);
        checkOutput("burst_b0_cout", {31'd0, rsp_cout}, 32'd1);
        applyStimulus(2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 1'b1);
        checkOutput("burst_b1_sum", {24'd0, rsp_sum}, 32'h01);
        checkOutput("burst_b1_id", {31'd0, rsp_id}, 32'd1);
        applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);

        $display("[TB] contention");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2'b11, 8'(k), 8'h03, 8'(k + 16), 8'h05, 2'b11, 1'b1);
            checkOutput("contend_id", {31'd0, rsp_id}, k % 2);
        end
        applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);

        $display("[TB] burst lock");
        applyStimulus(2'b11, 8'h10, 8'h20, 8'h77, 8'h11, 2'b10, 1'b1);
        applyStimulus(2'b10, 8'h00, 8'h00, 8'h77, 8'h11, 2'b10, 1'b1);
        applyStimulus(2'b10, 8'h00, 8'h00, 8'h77, 8'h11, 2'b10, 1'b1);
        applyStimulus(2'b11, 8'hF0, 8'h20, 8'h77, 8'h11, 2'b10, 1'b1);
        applyStimulus(2'b11, 8'h01, 8'h02, 8'h77, 8'h11, 2'b11, 1'b1);
        checkOutput("lock_owner_last", {31'd0, rsp_id}, 32'd0);
        applyStimulus(2'b10, 8'h00, 8'h00, 8'h77, 8'h11, 2'b11, 1'b1);
        checkOutput("lock_release_id", {31'd0, rsp_id}, 32'd1);
        checkOutput("lock_release_sum", {24'd0, rsp_sum}, 32'h88);
        applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(2'b01, 8'h40, 8'h05, 8'h00, 8'h00, 2'b11, 1'b1);
        heldSum = rsp_sum;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, 8'h01, 8'h01, 8'h02, 8'h02, 2'b11, 1'b0);
            checkOutput("bp_hold_sum", {24'd0, rsp_sum}, {24'd0, heldSum});
        end
        applyStimulus(2'b11, 8'h01, 8'h01, 8'h02, 8'h02, 2'b11, 1'b1);
        checkOutput("bp_release_sum", {24'd0, rsp_sum}, 32'h04);
        applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);

        $display("[TB] reset mid-burst");
        applyStimulus(2'b01, 8'hFF, 8'h01, 8'h00, 8'h00, 2'b00, 1'b1);
        resetDut();
        applyStimulus(2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 1'b1);
        checkOutput("post_reset_sum", {24'd0, rsp_sum}, 32'h00);
        checkOutput("post_reset_cout", {31'd0, rsp_cout}, 32'd0);
        applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 2; i++) begin
            pendValid[i] = 1'b0;
            pendA[i]     = 8'h00;
            pendB[i]     = 8'h00;
            pendLast[i]  = 1'b0;
            burstLen[i]  = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pendValid[i] && $urandom_range(0, 9) < 6) begin
                    newLast      = (burstLen[i] == 3) || ($urandom_range(0, 2) == 0);
                    pendValid[i] = 1'b1;
                    pendA[i]     = 8'($urandom);
                    pendB[i]     = 8'($urandom);
                    pendLast[i]  = newLast;
                end
            end
            driveInputs({pendValid[1], pendValid[0]}, pendA[0], pendB[0], pendA[1], pendB[1],
                        {pendLast[1], pendLast[0]}, ($urandom_range(0, 3) != 0));
            stepCycle(acc);
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    pendValid[i] = 1'b0;
                    burstLen[i]  = pendLast[i] ? 0 : burstLen[i] + 1;
                end
            end
        end
        driveInputs(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
        stepCycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
